// File: rtl/duck_hunt_ctrl_pkg.sv
// Shared types and constants for the Duck Hunt game controller.
package duck_game_pkg;

  localparam int COORD_W    = 12;
  localparam int DEF_DUCK_W = 96;
  localparam int DEF_DUCK_H = 60;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_HUNTING   = 3'd2,
    ST_RELOADING = 3'd3,
    ST_DEATH     = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_t;

  // Largest of the three dwell times; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/duck_hunt_ctrl_if.sv
// Bundle of mouse/duck inputs and HUD/sprite outputs of the game controller.
// master = environment side (mouse, duck motion, renderers), slave = controller.
interface duck_hunt_ctrl_if #(
  parameter int N_DUCKS = 2,
  parameter int SCORE_W = 7
) ();
  import duck_game_pkg::*;

  logic [COORD_W-1:0]         mouse_xpos;
  logic [COORD_W-1:0]         mouse_ypos;
  logic                       left_mouse;
  logic                       right_mouse;
  logic                       game_enable;
  logic [COORD_W*N_DUCKS-1:0] duck_xpos;
  logic [COORD_W*N_DUCKS-1:0] duck_ypos;
  logic [N_DUCKS-1:0]         duck_active;
  logic [N_DUCKS-1:0]         duck_hit;
  logic [2:0]                 bullets_in_magazine;
  logic [5:0]                 bullets_left;
  logic [SCORE_W-1:0]         my_score;
  logic                       hunt_start;
  logic                       show_reload_char;
  logic                       game_over;

  modport master (
    output mouse_xpos, mouse_ypos, left_mouse, right_mouse, game_enable,
    output duck_xpos, duck_ypos, duck_active,
    input  duck_hit, bullets_in_magazine, bullets_left, my_score,
    input  hunt_start, show_reload_char, game_over
  );

  modport slave (
    input  mouse_xpos, mouse_ypos, left_mouse, right_mouse, game_enable,
    input  duck_xpos, duck_ypos, duck_active,
    output duck_hit, bullets_in_magazine, bullets_left, my_score,
    output hunt_start, show_reload_char, game_over
  );

endinterface

// File: rtl/duck_hunt_ctrl_hitbox.sv
// Point-in-rectangle test for one duck. Edges are inclusive and the math is
// done one bit wider than the coordinates so a duck near 4095 cannot wrap.
module duck_hitbox
  import duck_game_pkg::*;
#(
  parameter int DUCK_W = DEF_DUCK_W,
  parameter int DUCK_H = DEF_DUCK_H
) (
  input  logic [COORD_W-1:0] point_x,
  input  logic [COORD_W-1:0] point_y,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  input  logic               active,
  output logic               hit
);

  localparam logic [COORD_W:0] W_EXT = DUCK_W[COORD_W:0];
  localparam logic [COORD_W:0] H_EXT = DUCK_H[COORD_W:0];

  logic [COORD_W:0] px, py, x_lo, y_lo, x_hi, y_hi;
  logic             in_x, in_y;

  assign px   = {1'b0, point_x};
  assign py   = {1'b0, point_y};
  assign x_lo = {1'b0, box_x};
  assign y_lo = {1'b0, box_y};
  assign x_hi = x_lo + W_EXT;
  assign y_hi = y_lo + H_EXT;

  assign in_x = (px >= x_lo) && (px <= x_hi);
  assign in_y = (py >= y_lo) && (py <= y_hi);
  assign hit  = active && in_x && in_y;

endmodule

// File: rtl/duck_hunt_ctrl.sv
// Duck Hunt round controller: round FSM, magazine/ammo bookkeeping and
// per-duck hit testing with lowest-index priority.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | not playing; magazine/ammo/score held at start values
// ST_COUNTDOWN | pre-round delay, COUNTDOWN_CYC cycles
// ST_HUNTING   | shots and reload requests accepted
// ST_RELOADING | timed reload, RELOAD_CYC cycles, then magazine refilled
// ST_DEATH     | pause after a hit, DEATH_CYC cycles
// ST_GAME_OVER | ammo exhausted; outputs frozen until game_enable drops
module duck_hunt_ctrl
  import duck_game_pkg::*;
#(
  parameter int N_DUCKS       = 2,
  parameter int MAG_SIZE      = 3,
  parameter int TOTAL_AMMO    = 27,
  parameter int DUCK_W        = DEF_DUCK_W,
  parameter int DUCK_H        = DEF_DUCK_H,
  parameter int COUNTDOWN_CYC = 40,
  parameter int DEATH_CYC     = 20,
  parameter int RELOAD_CYC    = 4,
  parameter int SCORE_W       = 7
) (
  input logic             clk,
  input logic             rst,
  duck_hunt_ctrl_if.slave bus
);

  localparam int TMR_MAX = max3(COUNTDOWN_CYC, DEATH_CYC, RELOAD_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] CD_LOAD     = TMR_W'(COUNTDOWN_CYC - 1);
  localparam logic [TMR_W-1:0] DEATH_LOAD  = TMR_W'(DEATH_CYC - 1);
  localparam logic [TMR_W-1:0] RELOAD_LOAD = TMR_W'(RELOAD_CYC - 1);
  localparam logic [2:0]       MAG_FULL    = 3'(MAG_SIZE);
  localparam logic [5:0]       MAG_FULL6   = 6'(MAG_SIZE);
  localparam logic [5:0]       AMMO_FULL   = 6'(TOTAL_AMMO);

  game_state_t        state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               left_prev, right_prev;
  logic               left_pe, right_pe;
  logic [2:0]         mag, mag_n;
  logic [5:0]         ammo, ammo_n;
  logic [SCORE_W-1:0] score, score_n;
  logic               prompt, prompt_n;
  logic [N_DUCKS-1:0] duck_hit_q, duck_hit_n;
  logic               hunt_q, over_q;
  logic [N_DUCKS-1:0] hit_vec, hit_sel;
  logic               any_hit;

  assign left_pe  = bus.left_mouse  & ~left_prev;
  assign right_pe = bus.right_mouse & ~right_prev;

  for (genvar i = 0; i < N_DUCKS; i++) begin : g_hitbox
    duck_hitbox #(
      .DUCK_W (DUCK_W),
      .DUCK_H (DUCK_H)
    ) u_hitbox (
      .point_x (bus.mouse_xpos),
      .point_y (bus.mouse_ypos),
      .box_x   (bus.duck_xpos[COORD_W*i +: COORD_W]),
      .box_y   (bus.duck_ypos[COORD_W*i +: COORD_W]),
      .active  (bus.duck_active[i]),
      .hit     (hit_vec[i])
    );
  end

  // Priority encoder: only the lowest-index hitting duck is credited.
  always_comb begin
    hit_sel = '0;
    any_hit = 1'b0;
    for (int i = 0; i < N_DUCKS; i++) begin
      if (hit_vec[i] && !any_hit) begin
        hit_sel[i] = 1'b1;
        any_hit    = 1'b1;
      end
    end
  end

  // Next-state, timer and bookkeeping decisions for the round.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    mag_n      = mag;
    ammo_n     = ammo;
    score_n    = score;
    prompt_n   = prompt;
    duck_hit_n = '0;

    case (state)
      ST_IDLE: begin
        mag_n    = MAG_FULL;
        ammo_n   = AMMO_FULL;
        score_n  = '0;
        prompt_n = 1'b0;
        timer_n  = '0;
        if (bus.game_enable) begin
          state_n = ST_COUNTDOWN;
          timer_n = CD_LOAD;
        end
      end

      ST_COUNTDOWN: begin
        if (timer == '0) state_n = ST_HUNTING;
        else             timer_n = timer - TMR_W'(1);
      end

      ST_HUNTING: begin
        // A left press always wins over a same-cycle right press.
        if (left_pe) begin
          if (mag != '0) begin
            mag_n  = mag - 3'd1;
            ammo_n = ammo - 6'd1;
            if (any_hit) begin
              duck_hit_n = hit_sel;
              if (score != '1) score_n = score + SCORE_W'(1);
              state_n = ST_DEATH;
              timer_n = DEATH_LOAD;
            end
            // Running dry ends the game even if this shot was a kill.
            if (ammo_n == '0) begin
              state_n = ST_GAME_OVER;
              timer_n = '0;
            end
          end else begin
            prompt_n = 1'b1;
          end
        end else if (right_pe && (mag < MAG_FULL) && (ammo > {3'b000, mag})) begin
          state_n = ST_RELOADING;
          timer_n = RELOAD_LOAD;
        end
      end

      ST_RELOADING: begin
        if (timer == '0) begin
          state_n  = ST_HUNTING;
          mag_n    = (ammo < MAG_FULL6) ? ammo[2:0] : MAG_FULL;
          prompt_n = 1'b0;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end

      ST_DEATH: begin
        if (timer == '0) state_n = ST_HUNTING;
        else             timer_n = timer - TMR_W'(1);
      end

      ST_GAME_OVER: begin
      end

      default: begin
        state_n = ST_IDLE;
        timer_n = '0;
      end
    endcase

    if ((mag_n == '0) && (ammo_n != '0)) prompt_n = 1'b1;

    // Abort overrides everything; start values are loaded on the way out so
    // nothing from the abandoned round is visible in IDLE.
    if ((state != ST_IDLE) && !bus.game_enable) begin
      state_n    = ST_IDLE;
      timer_n    = '0;
      mag_n      = MAG_FULL;
      ammo_n     = AMMO_FULL;
      score_n    = '0;
      prompt_n   = 1'b0;
      duck_hit_n = '0;
    end
  end

  // State, timer and button-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      left_prev  <= 1'b0;
      right_prev <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      left_prev  <= bus.left_mouse;
      right_prev <= bus.right_mouse;
    end
  end

  // Output registers; status flags are decoded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag        <= '0;
      ammo       <= '0;
      score      <= '0;
      prompt     <= 1'b0;
      duck_hit_q <= '0;
      hunt_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      mag        <= mag_n;
      ammo       <= ammo_n;
      score      <= score_n;
      prompt     <= prompt_n;
      duck_hit_q <= duck_hit_n;
      hunt_q     <= (state_n == ST_HUNTING) || (state_n == ST_RELOADING) ||
                    (state_n == ST_DEATH);
      over_q     <= (state_n == ST_GAME_OVER);
    end
  end

  assign bus.duck_hit            = duck_hit_q;
  assign bus.bullets_in_magazine = mag;
  assign bus.bullets_left        = ammo;
  assign bus.my_score            = score;
  assign bus.hunt_start          = hunt_q;
  assign bus.show_reload_char    = prompt;
  assign bus.game_over           = over_q;

endmodule

// File: tb/tb_duck_hunt_ctrl.sv
// Self-checking bench for duck_hunt_ctrl (default parameters, two ducks).
module tb_duck_hunt_ctrl;
  import duck_game_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  duck_hunt_ctrl_if #(.N_DUCKS(N), .SCORE_W(7)) bus ();

  duck_hunt_ctrl #(
    .N_DUCKS(N), .MAG_SIZE(3), .TOTAL_AMMO(27), .DUCK_W(96), .DUCK_H(60),
    .COUNTDOWN_CYC(40), .DEATH_CYC(20), .RELOAD_CYC(4), .SCORE_W(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] cx, cy;
    logic [11:0] x0, y0, x1, y1;
    logic [1:0]  act;
    logic [1:0]  exp_hit;
    int          exp_score;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ducks(input logic [11:0] x0, input logic [11:0] y0,
                           input logic [11:0] x1, input logic [11:0] y1,
                           input logic [1:0] act);
    bus.duck_xpos   = {x1, x0};
    bus.duck_ypos   = {y1, y0};
    bus.duck_active = act;
  endtask

  task automatic fire(input logic [11:0] x, input logic [11:0] y);
    bus.mouse_xpos = x;
    bus.mouse_ypos = y;
    bus.left_mouse = 1'b1;
    tick();
  endtask

  task automatic release_left();
    bus.left_mouse = 1'b0;
    tick();
  endtask

  task automatic shoot_miss();
    set_ducks(12'd0, 12'd0, 12'd0, 12'd0, 2'b00);
    fire(12'd500, 12'd500);
    release_left();
  endtask

  // Right press, then wait out the 4-cycle reload.
  task automatic do_reload();
    bus.right_mouse = 1'b1;
    tick();
    bus.right_mouse = 1'b0;
    tick(4);
  endtask

  task automatic start_game();
    bus.left_mouse  = 1'b0;
    bus.right_mouse = 1'b0;
    bus.game_enable = 1'b0;
    tick(2);
    bus.game_enable = 1'b1;
    tick(41);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " duck_hit"},  bus.duck_hit, 0);
    check({tag, " mag"},       bus.bullets_in_magazine, 0);
    check({tag, " left"},      bus.bullets_left, 0);
    check({tag, " score"},     bus.my_score, 0);
    check({tag, " hunt"},      bus.hunt_start, 0);
    check({tag, " prompt"},    bus.show_reload_char, 0);
    check({tag, " game_over"}, bus.game_over, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cx     cy     x0     y0     x1     y1    act  hit   sc
    vecs[0]  = '{12'd196, 12'd260, 12'd100, 12'd200, 12'd1000, 12'd1000, 2'b11, 2'b01, 1};
    vecs[1]  = '{12'd197, 12'd260, 12'd100, 12'd200, 12'd1000, 12'd1000, 2'b11, 2'b00, 0};
    vecs[2]  = '{12'd100, 12'd200, 12'd100, 12'd200, 12'd1000, 12'd1000, 2'b11, 2'b01, 1};
    vecs[3]  = '{12'd99,  12'd200, 12'd100, 12'd200, 12'd1000, 12'd1000, 2'b11, 2'b00, 0};
    vecs[4]  = '{12'd150, 12'd261, 12'd100, 12'd200, 12'd1000, 12'd1000, 2'b11, 2'b00, 0};
    vecs[5]  = '{12'd150, 12'd230, 12'd100, 12'd200, 12'd120,  12'd210,  2'b11, 2'b01, 1};
    vecs[6]  = '{12'd150, 12'd230, 12'd100, 12'd200, 12'd120,  12'd210,  2'b10, 2'b10, 1};
    vecs[7]  = '{12'd150, 12'd230, 12'd100, 12'd200, 12'd120,  12'd210,  2'b00, 2'b00, 0};
    vecs[8]  = '{12'd4095, 12'd4095, 12'd0, 12'd0,   12'd4050, 12'd4080, 2'b10, 2'b10, 1};
    vecs[9]  = '{12'd10,  12'd10,  12'd3000, 12'd3000, 12'd4050, 12'd4080, 2'b11, 2'b00, 0};
    vecs[10] = '{12'd196, 12'd260, 12'd100, 12'd200, 12'd196,  12'd260,  2'b11, 2'b01, 1};

    rst             = 1'b1;
    bus.mouse_xpos  = '0;
    bus.mouse_ypos  = '0;
    bus.left_mouse  = 1'b0;
    bus.right_mouse = 1'b0;
    bus.game_enable = 1'b0;
    set_ducks(12'd0, 12'd0, 12'd0, 12'd0, 2'b00);
    tick(2);
    check_all_zero("por");
    rst = 1'b0;

    // Reset in the middle of HUNTING, then restart with enable held high.
    start_game();
    shoot_miss();
    check("pre-reset mag", bus.bullets_in_magazine, 2);
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    tick(2);
    check_all_zero("held rst");
    rst = 1'b0;
    tick(40);
    check("countdown last cycle hunt", bus.hunt_start, 0);
    check("countdown mag", bus.bullets_in_magazine, 3);
    tick();
    check("hunt after 40", bus.hunt_start, 1);
    check("start mag", bus.bullets_in_magazine, 3);
    check("start left", bus.bullets_left, 27);

    // Boundary hit and exact DEATH dwell.
    set_ducks(12'd100, 12'd200, 12'd1000, 12'd1000, 2'b01);
    fire(12'd196, 12'd260);
    check("edge hit duck_hit", bus.duck_hit, 2'b01);
    check("edge hit score", bus.my_score, 1);
    check("edge hit mag", bus.bullets_in_magazine, 2);
    check("edge hit left", bus.bullets_left, 26);
    release_left();
    check("hit pulse width", bus.duck_hit, 0);
    tick(18);
    fire(12'd196, 12'd260);
    check("death last cycle mag", bus.bullets_in_magazine, 2);
    check("death last cycle score", bus.my_score, 1);
    check("death last cycle duck_hit", bus.duck_hit, 0);
    release_left();
    fire(12'd196, 12'd260);
    check("second hit duck_hit", bus.duck_hit, 2'b01);
    check("second hit score", bus.my_score, 2);
    check("second hit left", bus.bullets_left, 25);
    release_left();
    tick(19);
    fire(12'd197, 12'd260);
    check("post-death miss mag", bus.bullets_in_magazine, 0);
    check("post-death miss left", bus.bullets_left, 24);
    check("post-death miss score", bus.my_score, 2);
    check("post-death miss duck_hit", bus.duck_hit, 0);
    check("empty mag prompt", bus.show_reload_char, 1);
    release_left();

    // Table-driven hit tests, each from a fresh round.
    for (int v = 0; v < 11; v++) begin
      start_game();
      set_ducks(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].act);
      fire(vecs[v].cx, vecs[v].cy);
      check($sformatf("vec%0d duck_hit", v), bus.duck_hit, vecs[v].exp_hit);
      check($sformatf("vec%0d score", v), bus.my_score, vecs[v].exp_score);
      check($sformatf("vec%0d mag", v), bus.bullets_in_magazine, 2);
      check($sformatf("vec%0d left", v), bus.bullets_left, 26);
      release_left();
      check($sformatf("vec%0d pulse end", v), bus.duck_hit, 0);
    end

    // Empty magazine, prompt, timed reload.
    start_game();
    repeat (3) shoot_miss();
    check("empty mag", bus.bullets_in_magazine, 0);
    check("empty left", bus.bullets_left, 24);
    check("empty prompt", bus.show_reload_char, 1);
    fire(12'd500, 12'd500);
    check("dry click mag", bus.bullets_in_magazine, 0);
    check("dry click left", bus.bullets_left, 24);
    check("dry click prompt", bus.show_reload_char, 1);
    release_left();
    bus.right_mouse = 1'b1;
    tick();
    bus.right_mouse = 1'b0;
    tick(3);
    check("reloading mag", bus.bullets_in_magazine, 0);
    check("reloading prompt", bus.show_reload_char, 1);
    tick();
    check("reloaded mag", bus.bullets_in_magazine, 3);
    check("reloaded prompt", bus.show_reload_char, 0);
    check("reloaded left", bus.bullets_left, 24);

    // Partial top-up, then drain to bullets_left = 2 with an empty magazine.
    shoot_miss();
    do_reload();
    check("topup mag", bus.bullets_in_magazine, 3);
    check("topup left", bus.bullets_left, 23);
    for (int g = 0; g < 7; g++) begin
      repeat (3) shoot_miss();
      if (g < 6) do_reload();
    end
    check("drain mag", bus.bullets_in_magazine, 0);
    check("drain left", bus.bullets_left, 2);
    do_reload();
    check("partial mag", bus.bullets_in_magazine, 2);
    check("partial prompt", bus.show_reload_char, 0);
    shoot_miss();
    check("penultimate left", bus.bullets_left, 1);
    check("penultimate over", bus.game_over, 0);
    set_ducks(12'd100, 12'd200, 12'd1000, 12'd1000, 2'b01);
    fire(12'd150, 12'd230);
    check("final duck_hit", bus.duck_hit, 2'b01);
    check("final score", bus.my_score, 1);
    check("final left", bus.bullets_left, 0);
    check("final mag", bus.bullets_in_magazine, 0);
    check("final game_over", bus.game_over, 1);
    check("final hunt", bus.hunt_start, 0);
    release_left();
    check("over pulse end", bus.duck_hit, 0);
    fire(12'd150, 12'd230);
    check("over frozen score", bus.my_score, 1);
    check("over frozen flag", bus.game_over, 1);
    release_left();
    bus.game_enable = 1'b0;
    tick();
    check("abort game_over", bus.game_over, 0);
    tick();
    check("idle mag", bus.bullets_in_magazine, 3);
    check("idle left", bus.bullets_left, 27);
    check("idle score", bus.my_score, 0);

    // Same-cycle left+right: the shot wins and no reload starts.
    start_game();
    shoot_miss();
    bus.mouse_xpos  = 12'd500;
    bus.mouse_ypos  = 12'd500;
    bus.left_mouse  = 1'b1;
    bus.right_mouse = 1'b1;
    tick();
    check("both mag", bus.bullets_in_magazine, 1);
    check("both left", bus.bullets_left, 25);
    bus.left_mouse  = 1'b0;
    bus.right_mouse = 1'b0;
    tick(6);
    check("no reload mag", bus.bullets_in_magazine, 1);
    do_reload();
    check("later reload mag", bus.bullets_in_magazine, 3);
    // Reload with a full magazine is ignored, so a shot right after lands.
    bus.right_mouse = 1'b1;
    tick();
    bus.right_mouse = 1'b0;
    fire(12'd500, 12'd500);
    check("full reload ignored mag", bus.bullets_in_magazine, 2);
    check("full reload ignored left", bus.bullets_left, 24);
    release_left();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/duck_hunt_ctrl.md
Name: duck_hunt_ctrl

Overview:
Parametrised game controller for Duck Hunt. It sits between the mouse/duck-motion blocks and the HUD/sprite renderers.
- Runs the round FSM: countdown, hunting, timed reload, death pause, game over.
- Tracks a magazine and a total ammo pool.
- Hit-tests every shot against N independent ducks and reports which duck died.
- Generalises the single-duck controller: N ducks, configurable magazine/ammo/timing, partial reload, game-over detection, per-duck hit pulses.

Parameters:
N_DUCKS, 2, number of ducks hit-tested (1..8)
MAG_SIZE, 3, magazine capacity (1..7)
TOTAL_AMMO, 27, initial ammo including the magazine (MAG_SIZE..63)
DUCK_W, 96, hitbox width in pixels
DUCK_H, 60, hitbox height in pixels
COUNTDOWN_CYC, 40, cycles spent in COUNTDOWN
DEATH_CYC, 20, cycles spent in DEATH after a hit
RELOAD_CYC, 4, cycles spent in RELOADING
SCORE_W, 7, score width

Ports:
clk  in  1  system clock, posedge
rst  in  1  asynchronous, active-high reset
mouse_xpos  in  12  cursor x
mouse_ypos  in  12  cursor y
left_mouse  in  1  fire button level
right_mouse  in  1  reload button level
game_enable  in  1  level; high = play, low = abort/return to idle
duck_xpos  in  12*N_DUCKS  packed, duck i at [12i+11:12i], top-left x
duck_ypos  in  12*N_DUCKS  packed, top-left y
duck_active  in  N_DUCKS  duck i is on screen and hittable
duck_hit  out  N_DUCKS  one-cycle one-hot pulse, duck i shot
bullets_in_magazine  out  3  rounds in magazine
bullets_left  out  6  total rounds left, magazine included
my_score  out  SCORE_W  ducks hit
hunt_start  out  1  high in HUNTING, RELOADING, DEATH
show_reload_char  out  1  "RELOAD" prompt
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async assert, released on clk): state IDLE, all outputs 0, edge-detect registers 0, timer 0.
- All outputs are registered.
- Edge detect: posedge = level & ~prev, where prev is registered. An action is taken in the cycle the posedge is seen and is visible on outputs after the next clk edge (1-cycle latency).
- States: IDLE, COUNTDOWN, HUNTING, RELOADING, DEATH, GAME_OVER.
- Global abort: game_enable low in any state other than IDLE → IDLE next cycle. This has priority over every other transition.
- IDLE:
  - Magazine = MAG_SIZE, bullets_left = TOTAL_AMMO, score 0, prompt 0.
  - game_enable high → COUNTDOWN with timer = COUNTDOWN_CYC-1.
- COUNTDOWN / RELOADING / DEATH: timer decrements each cycle; leave on the cycle timer==0. Dwell is exactly the parameter value in cycles. Clicks in these states are ignored and consume nothing.
- COUNTDOWN → HUNTING.
- HUNTING, left posedge, magazine>0:
  - Magazine−1 and bullets_left−1.
  - Hit test on duck i: duck_active[i], x in [xpos, xpos+DUCK_W], y in [ypos, ypos+DUCK_H], inclusive. Comparisons use 13 bits so there is no wrap near 4095.
  - Only the lowest hitting index scores. That duck gets duck_hit pulsed, score +1 (saturating at all-ones), and the FSM goes to DEATH with timer = DEATH_CYC-1.
  - Miss: stay in HUNTING.
- HUNTING, left posedge, magazine==0: no ammo change; show_reload_char set to 1.
- HUNTING, right posedge:
  - Reload only if magazine<MAG_SIZE and bullets_left>magazine: → RELOADING with timer = RELOAD_CYC-1.
  - Otherwise ignored.
- Simultaneous left and right posedge in HUNTING: the shot wins; reload is ignored.
- Leaving RELOADING: magazine = min(MAG_SIZE, bullets_left), show_reload_char cleared, → HUNTING.
- show_reload_char is also driven to 1 combinationally-registered whenever magazine==0 and bullets_left>0.
- Game over: bullets_left==0 after any shot → GAME_OVER. This takes priority over DEATH, but the score still increments and duck_hit still pulses.
- GAME_OVER: game_over=1, outputs frozen until game_enable low → IDLE.
- Reset mid-round: immediate return to reset values; no pending reload or score is kept.

Decomposition:
- Package duck_game_pkg:
  - state enum (3-bit typedef game_state_t)
  - default DUCK_W/DUCK_H
  - coordinate width constant COORD_W=12
- Sub-module duck_hitbox: combinational point-in-rectangle test, parametrised by DUCK_W/DUCK_H. Generate N_DUCKS instances; a priority encoder in the top selects the lowest hitting index.

Test Plan:
1. Reset mid-HUNTING, then enable: all outputs 0 during reset. After enable, exactly 40 cycles of COUNTDOWN, then hunt_start=1, mag=3, bullets_left=27.
2. Hit at the boundary: duck0 at (100,200), click at (196,260) → duck_hit=2'b01 for one cycle, score=1, mag=2, left=26, 20-cycle DEATH. A click at (197,260) is a miss.
3. Overlap: both ducks active covering the click point → duck_hit=2'b01 only, score +1.
4. Empty magazine: 3 misses then a click → mag=0, left=24, show_reload_char=1. Right click → 4-cycle RELOADING, then mag=3, prompt 0.
5. Partial reload: fire to bullets_left=2 with mag=0, reload → mag=2. The next 2 shots set left=0 → game_over=1. Drop game_enable → IDLE.
6. Same-cycle left+right posedge with mag=2 → shot taken (mag=1), no RELOADING entered.
